// File: rtl/adda_pkg.sv
// rtl/adda_pkg.sv - shared ADC/DAC sample constants, entry type and offset-binary conversions
package adda_pkg;

    localparam int ADDA_DATA_WIDTH = 14;

    typedef struct packed {
        logic                       otr;
        logic [ADDA_DATA_WIDTH-1:0] data;
    } fifo_entry_t;

    // Offset binary and two's complement differ only in the MSB, so one flip serves both directions.
    function automatic logic [31:0] offset_to_signed(input logic [31:0] word, input int unsigned width);
        return word ^ (32'd1 << (width - 1));
    endfunction

    function automatic logic [31:0] signed_to_offset(input logic [31:0] word, input int unsigned width);
        return offset_to_signed(word, width);
    endfunction

endpackage

// File: rtl/adc_rx_offset_to_signed_if.sv
// rtl/adc_rx_offset_to_signed_if.sv - downstream sample handshake (valid/busy) between receiver and consumer
interface adc_rx_offset_to_signed_if #(
    parameter int DATA_WIDTH = 14
);
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  dataOut_otr;
    logic                  out_valid;
    logic                  outbusy;

    modport master (
        output dataOut,
        output dataOut_otr,
        output out_valid,
        input  outbusy
    );

    modport slave (
        input  dataOut,
        input  dataOut_otr,
        input  out_valid,
        output outbusy
    );
endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous first-word-fall-through FIFO with level, full and empty
module sample_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (level_q == LW'(DEPTH));
        empty    = (level_q == '0);
        do_pop   = pop && !empty;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/adc_rx_offset_to_signed.sv
// rtl/adc_rx_offset_to_signed.sv - ADC capture, offset-binary to signed conversion, buffered output with OTR and overrun tracking
module adc_rx_offset_to_signed
    import adda_pkg::*;
#(
    parameter int DATA_WIDTH = ADDA_DATA_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          enable,
    input  logic [DATA_WIDTH-1:0]         adc_data,
    input  logic                          adc_otr,
    input  logic                          sample_en,
    adc_rx_offset_to_signed_if.master     out_if,
    output logic                          otr_flag,
    output logic [CNT_WIDTH-1:0]          overrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                  cap_valid_q, cap_valid_d;
    logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;
    logic                  cap_otr_q, cap_otr_d;
    logic                  otr_flag_q, otr_flag_d;
    logic [CNT_WIDTH-1:0]  overrun_q, overrun_d;

    logic [DATA_WIDTH:0]   fifo_rdata;
    logic [LW-1:0]         level;
    logic                  full, empty, pop_eff, drop;

    always_comb begin
        cap_valid_d = !clr && sample_en && enable;
        cap_data_d  = cap_data_q;
        cap_otr_d   = cap_otr_q;
        if (sample_en && enable) begin
            cap_data_d = DATA_WIDTH'(offset_to_signed(32'(adc_data), DATA_WIDTH));
            cap_otr_d  = adc_otr;
        end

        pop_eff = !empty && !out_if.outbusy;
        drop    = cap_valid_q && full && !pop_eff;

        otr_flag_d = otr_flag_q;
        overrun_d  = overrun_q;
        if (clr) begin
            otr_flag_d = 1'b0;
            overrun_d  = '0;
        end else begin
            // The flag records the event even when the entry itself is lost to overrun.
            if (cap_valid_q && cap_otr_q) begin
                otr_flag_d = 1'b1;
            end
            if (drop && (overrun_q != '1)) begin
                overrun_d = overrun_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
            cap_otr_q   <= 1'b0;
            otr_flag_q  <= 1'b0;
            overrun_q   <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_data_q  <= cap_data_d;
            cap_otr_q   <= cap_otr_d;
            otr_flag_q  <= otr_flag_d;
            overrun_q   <= overrun_d;
        end
    end

    sample_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (cap_valid_q && !clr),
        .pop   (!out_if.outbusy),
        .wdata ({cap_otr_q, cap_data_q}),
        .rdata (fifo_rdata),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign out_if.dataOut     = fifo_rdata[DATA_WIDTH-1:0];
    assign out_if.dataOut_otr = fifo_rdata[DATA_WIDTH];
    assign out_if.out_valid   = !empty;
    assign otr_flag           = otr_flag_q;
    assign overrun_cnt        = overrun_q;
    assign fifo_level         = level;

endmodule

// File: tb/tb_adc_rx_offset_to_signed.sv
// tb/tb_adc_rx_offset_to_signed.sv - scoreboard bench for adc_rx_offset_to_signed
module tb_adc_rx_offset_to_signed;
    import adda_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        enable = 1'b0;
    logic [13:0] adc_data = '0;
    logic        adc_otr = 1'b0;
    logic        sample_en = 1'b0;
    logic        otr_flag;
    logic [15:0] overrun_cnt;
    logic [3:0]  fifo_level;

    adc_rx_offset_to_signed_if #(.DATA_WIDTH(14)) out_if ();

    adc_rx_offset_to_signed #(
        .DATA_WIDTH (14),
        .FIFO_DEPTH (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .enable      (enable),
        .adc_data    (adc_data),
        .adc_otr     (adc_otr),
        .sample_en   (sample_en),
        .out_if      (out_if.master),
        .otr_flag    (otr_flag),
        .overrun_cnt (overrun_cnt),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    fifo_entry_t exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          max_lvl = 0;
    bit          track = 1'b0;

    logic [13:0] vec_in  [10] = '{14'h0000, 14'h3FFF, 14'h2000, 14'h1FFF, 14'h0001,
                                  14'h3FFE, 14'h2ABC, 14'h1543, 14'h0FFF, 14'h3000};
    logic [13:0] vec_exp [10] = '{14'h2000, 14'h1FFF, 14'h0000, 14'h3FFF, 14'h2001,
                                  14'h1FFE, 14'h0ABC, 14'h3543, 14'h2FFF, 14'h1000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid and not busy.
    always @(negedge clk) begin
        fifo_entry_t e;
        if (rst_n) begin
            if (track && int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (out_if.out_valid && !out_if.outbusy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 32'(out_if.dataOut), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_data", 32'(out_if.dataOut), 32'(e.data));
                    check("pop_otr", 32'(out_if.dataOut_otr), 32'(e.otr));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [13:0] d, input logic otr, input logic [13:0] exp, input bit accepted);
        fifo_entry_t e;
        adc_data  = d;
        adc_otr   = otr;
        sample_en = 1'b1;
        if (accepted) begin
            e.otr  = otr;
            e.data = exp;
            exp_q.push_back(e);
        end
        step();
        sample_en = 1'b0;
        adc_otr   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_if.out_valid) && n < 50) begin
            step();
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        out_if.outbusy = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(out_if.out_valid), 32'd0);
        check("rst_dataOut", 32'(out_if.dataOut), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
        check("rst_otr_flag", 32'(otr_flag), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        step();

        // Two-cycle latency for a single sample into an empty FIFO.
        strobe(14'h0000, 1'b0, 14'h2000, 1'b1);
        check("lat_edge_k", 32'(out_if.out_valid), 32'd0);
        step();
        check("lat_edge_k1_valid", 32'(out_if.out_valid), 32'd1);
        check("lat_edge_k1_data", 32'(out_if.dataOut), 32'h2000);
        step();
        check("lat_popped", 32'(out_if.out_valid), 32'd0);

        // Back-to-back strobes with a free consumer.
        max_lvl = 0;
        track   = 1'b1;
        strobe(14'h2000, 1'b0, 14'h0000, 1'b1);
        strobe(14'h3FFF, 1'b0, 14'h1FFF, 1'b1);
        strobe(14'h1FFF, 1'b0, 14'h3FFF, 1'b1);
        drain();
        track = 1'b0;
        check("b2b_max_level_le2", 32'(max_lvl <= 2), 32'd1);

        // Overrun: 10 strobes into a blocked depth-8 FIFO.
        out_if.outbusy = 1'b1;
        for (int i = 0; i < 10; i++) strobe(vec_in[i], 1'b0, vec_exp[i], i < 8);
        step();
        step();
        check("full_level", 32'(fifo_level), 32'd8);
        check("full_overrun", 32'(overrun_cnt), 32'd2);

        // Full FIFO with a push and a pop on the same edge.
        adc_data  = 14'h1234;
        sample_en = 1'b1;
        step();
        sample_en      = 1'b0;
        out_if.outbusy = 1'b0;
        exp_q.push_back('{otr: 1'b0, data: 14'h3234});
        step();
        out_if.outbusy = 1'b1;
        check("pushpop_level", 32'(fifo_level), 32'd8);
        check("pushpop_overrun", 32'(overrun_cnt), 32'd2);
        out_if.outbusy = 1'b0;
        drain();

        // Out-of-range sample: flag is sticky across the pop.
        out_if.outbusy = 1'b1;
        strobe(14'h0005, 1'b1, 14'h2005, 1'b1);
        step();
        check("otr_flag_set", 32'(otr_flag), 32'd1);
        check("otr_head_bit", 32'(out_if.dataOut_otr), 32'd1);
        out_if.outbusy = 1'b0;
        drain();
        check("otr_flag_sticky", 32'(otr_flag), 32'd1);

        // clr with a held sample and a nonzero overrun count.
        out_if.outbusy = 1'b1;
        strobe(14'h0007, 1'b0, 14'h2007, 1'b0);
        step();
        check("pre_clr_valid", 32'(out_if.out_valid), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_otr_flag", 32'(otr_flag), 32'd0);
        check("clr_overrun", 32'(overrun_cnt), 32'd0);
        check("clr_out_valid", 32'(out_if.out_valid), 32'd0);
        check("clr_level", 32'(fifo_level), 32'd0);

        // enable low blocks capture.
        enable = 1'b0;
        out_if.outbusy = 1'b0;
        strobe(14'h0011, 1'b0, 14'h2011, 1'b0);
        step();
        step();
        check("disabled_no_valid", 32'(out_if.out_valid), 32'd0);
        enable = 1'b1;

        // Asynchronous reset with 5 entries held.
        out_if.outbusy = 1'b1;
        for (int i = 0; i < 5; i++) strobe(vec_in[i], 1'b0, vec_exp[i], 1'b1);
        step();
        step();
        check("held_level", 32'(fifo_level), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_if.out_valid), 32'd0);
        check("async_rst_level", 32'(fifo_level), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        out_if.outbusy = 1'b0;
        strobe(14'h3FFF, 1'b0, 14'h1FFF, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_rx_offset_to_signed.md
Name: adc_rx_offset_to_signed

Overview:
- ADC-side receive block, the opposite end of the DAC output path: captures offset-binary ADC words and converts them to signed two's complement for the processing chain.
- Buffers samples in a small FIFO and presents them downstream with a valid/busy handshake.
- Tracks ADC out-of-range events and counts samples dropped on overrun.

Parameters:
- DATA_WIDTH, 14, ADC sample width in bits.
- FIFO_DEPTH, 8, buffer entries; power of two, at least 2.
- CNT_WIDTH, 16, width of the saturating overrun counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: empties the FIFO, clears overrun_cnt and otr_flag.
- enable  in  1  capture enable; when low, no new samples are accepted.
- adc_data  in  DATA_WIDTH  offset-binary ADC word (0 = most negative).
- adc_otr  in  1  ADC out-of-range bit, qualified by sample_en.
- sample_en  in  1  one-cycle strobe marking adc_data valid.
- dataOut  out  DATA_WIDTH  signed two's-complement sample at the FIFO head.
- dataOut_otr  out  1  OTR bit stored with the head sample.
- out_valid  out  1  FIFO not empty.
- outbusy  in  1  consumer busy; a pop occurs when out_valid=1 and outbusy=0.
- otr_flag  out  1  sticky: set by any accepted sample with adc_otr=1.
- overrun_cnt  out  CNT_WIDTH  count of dropped samples, saturating.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, pointers 0, capture register invalid, out_valid=0, dataOut=0, dataOut_otr=0, otr_flag=0, overrun_cnt=0, fifo_level=0.
- Conversion: converted = {~adc_data[MSB], adc_data[MSB-1:0]}.
  - Examples for 14 bits: 0x2000 -> 0x0000; 0x0000 -> 0x2000 (-8192); 0x3FFF -> 0x1FFF (+8191); 0x1FFF -> 0x3FFF (-1).
- Stage 1 (capture register): on a clk edge with sample_en=1 and enable=1, register converted data, adc_otr and a valid bit. Otherwise the valid bit clears.
- Stage 2 (push): a valid capture-register entry is written to the FIFO on the next edge.
- Latency: sample_en sampled at edge k gives out_valid=1 and the sample on dataOut after edge k+1 when the FIFO was empty (2 cycles).
- FIFO is first-word-fall-through. dataOut and dataOut_otr show mem[rd_ptr] whenever out_valid=1 and hold 0 when empty.
- Pop: at an edge with out_valid=1 and outbusy=0, rd_ptr advances.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are determined from fifo_level.
- Full with a push and no pop in the same cycle: the sample is dropped and overrun_cnt increments, holding at 2^CNT_WIDTH-1.
- Full with push and pop in the same cycle: both succeed, no drop, level unchanged.
- Empty: outbusy is ignored and no pointer moves.
- otr_flag sets when an entry with otr=1 is pushed. It stays set until clr or reset, including when that entry is dropped on overrun.
- clr: at the edge it is sampled high, FIFO empties, the capture register invalidates, and counter and flag clear. clr wins over a simultaneous push, pop or otr set.
- enable low: stage 1 stops capturing. An entry already in stage 1 is still pushed, and the FIFO continues to drain normally.
- rst_n asserted mid-operation: all state returns to reset values immediately. The first capture is possible on the first edge after release.

Decomposition:
- Shared package adda_pkg holds:
  - DATA_WIDTH default constant;
  - the offset-binary-to-signed conversion function, shared with the signed-to-offset function used on the DAC path;
  - the FIFO entry struct {otr, data}.
- One sub-module: sample_fifo, a synchronous FWFT FIFO with push/pop, level, full and empty, parameterised on width and depth. The overrun counter and otr_flag stay in the top level.

Test Plan:
- Reset then single strobe of adc_data=0x0000, outbusy=0 -> out_valid rises 2 cycles later, dataOut=0x2000, popped next edge, out_valid=0.
- Strobes of 0x2000, 0x3FFF and 0x1FFF on consecutive cycles with outbusy=0 -> dataOut sequence 0x0000, 0x1FFF, 0x3FFF in order, fifo_level never exceeds 2.
- outbusy=1 with 10 consecutive strobes (DEPTH=8) -> fifo_level=8, overrun_cnt=2. Release outbusy -> first 8 samples appear in order.
- FIFO full, outbusy=0 and a strobe in the same cycle -> level stays 8 and overrun_cnt does not change.
- Strobe with adc_otr=1 -> otr_flag=1 and dataOut_otr=1 on that sample. Flag persists after the pop. clr pulse -> otr_flag=0, overrun_cnt=0, out_valid=0.
- rst_n pulled low with 5 entries held -> out_valid=0 and fifo_level=0 immediately, without a clock edge.
